// File: rtl/ren_conv_wb_dispatch.sv
// ren_conv_wb_dispatch: Wishbone slave-side dispatcher that fans one master
// port out to NO_OF_INSTS convolver slaves. The base page is ADDR_BASE[31:12].
// adr[11:8] picks a slave. Index 0xF is a small local CSR block.
// Optional ack watchdog: define REN_DISP_TIMEOUT_EN to build it in.
module ren_conv_wb_dispatch #(
    parameter int          NO_OF_INSTS = 11,
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NO_OF_INSTS-1:0]   m_wb_rst_o,
    output logic [NO_OF_INSTS-1:0]   m_wbs_stb_o,
    input  logic [NO_OF_INSTS-1:0]   m_wbs_ack_i,
    input  logic [32*NO_OF_INSTS-1:0] m_wbs_dat_i
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_BUSY = 2'd1;
    localparam logic [1:0]  ST_ACK  = 2'd2;
    localparam logic [4:0]  N_L     = 5'(NO_OF_INSTS);
    localparam logic [31:0] ID_VAL  = 32'h52C0_0000 | 32'(NO_OF_INSTS);

    logic [1:0]             state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [NO_OF_INSTS-1:0] stb_q, stb_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [NO_OF_INSTS-1:0] soft_rst_q, soft_rst_d;

    logic                   req;
    logic                   base_hit;
    logic [3:0]             req_idx;
    logic                   slave_ok;
    logic                   csr_hit;
    logic [31:0]            soft_ext;
    logic [31:0]            soft_wr;
    logic [31:0]            to_stat;
    logic [31:0]            csr_rd;
    logic [NO_OF_INSTS-1:0] req_onehot;
    logic [31:0]            slave_dat [NO_OF_INSTS];
    logic                   sel_ack;

`ifdef REN_DISP_TIMEOUT_EN
    localparam logic [15:0] TO_L = 16'(TIMEOUT_CYC);
    logic        to_flag_q, to_flag_d;
    logic [3:0]  to_idx_q, to_idx_d;
    logic [15:0] cnt_q, cnt_d;
    assign to_stat = {to_flag_q, 27'd0, to_idx_q};
`else
    assign to_stat = 32'd0;
`endif

    assign req      = wbs_stb_i & wbs_cyc_i;
    assign base_hit = (wbs_adr_i[31:12] == ADDR_BASE[31:12]);
    assign req_idx  = wbs_adr_i[11:8];
    assign soft_ext = 32'(soft_rst_q);
    // A slave held in soft reset is treated like an unmapped hole.
    assign slave_ok = base_hit & ({1'b0, req_idx} < N_L) & ~soft_ext[req_idx];
    assign csr_hit  = base_hit & (req_idx == 4'hF);
    assign sel_ack  = m_wbs_ack_i[idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < NO_OF_INSTS; gi++) begin : g_slv
            assign req_onehot[gi] = (req_idx == 4'(gi));
            assign slave_dat[gi]  = m_wbs_dat_i[32*gi +: 32];
        end
        // Byte-lane merge for SOFT_RST writes; bits above NO_OF_INSTS are dropped.
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign soft_wr[8*gi +: 8] = wbs_sel_i[gi] ? wbs_dat_i[8*gi +: 8]
                                                      : soft_ext[8*gi +: 8];
        end
    endgenerate

    // Local CSR read mux.
    always_comb begin
        csr_rd = 32'd0;
        case (wbs_adr_i[7:0])
            8'h00:   csr_rd = soft_ext;
            8'h04:   csr_rd = to_stat;
            8'h08:   csr_rd = ID_VAL;
            default: csr_rd = 32'd0;
        endcase
    end

    // Dispatcher FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stb_d      = stb_q;
        ack_d      = 1'b0;
        dat_d      = dat_q;
        soft_rst_d = soft_rst_q;
`ifdef REN_DISP_TIMEOUT_EN
        to_flag_d  = to_flag_q;
        to_idx_d   = to_idx_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (slave_ok) begin
                        idx_d   = req_idx;
                        stb_d   = req_onehot;
                        state_d = ST_BUSY;
`ifdef REN_DISP_TIMEOUT_EN
                        cnt_d   = 16'd1;
`endif
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (csr_hit) begin
                            dat_d = csr_rd;
                            if (wbs_we_i) begin
                                if (wbs_adr_i[7:0] == 8'h00) begin
                                    soft_rst_d = soft_wr[NO_OF_INSTS-1:0];
                                end
`ifdef REN_DISP_TIMEOUT_EN
                                if (wbs_adr_i[7:0] == 8'h04 && wbs_sel_i[3] && wbs_dat_i[31]) begin
                                    to_flag_d = 1'b0;
                                end
`endif
                            end
                        end else begin
                            dat_d = 32'hBADA_DD00 | {28'd0, req_idx};
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: quietly return without an ack.
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    stb_d   = '0;
                    dat_d   = slave_dat[idx_q];
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
`ifdef REN_DISP_TIMEOUT_EN
                end else if (cnt_q == TO_L) begin
                    stb_d     = '0;
                    dat_d     = 32'hDEAD_0000 | {28'd0, idx_q};
                    to_flag_d = 1'b1;
                    to_idx_d  = idx_q;
                    ack_d     = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            stb_q      <= '0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            soft_rst_q <= '0;
`ifdef REN_DISP_TIMEOUT_EN
            to_flag_q  <= 1'b0;
            to_idx_q   <= 4'd0;
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stb_q      <= stb_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            soft_rst_q <= soft_rst_d;
`ifdef REN_DISP_TIMEOUT_EN
            to_flag_q  <= to_flag_d;
            to_idx_q   <= to_idx_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign m_wbs_stb_o = stb_q;
    assign m_wb_rst_o  = {NO_OF_INSTS{wb_rst_i}} | soft_rst_q;

endmodule

// File: tb/tb_ren_conv_wb_dispatch.sv
// Directed bench for ren_conv_wb_dispatch (11 slaves, watchdog limit 8 when
// REN_DISP_TIMEOUT_EN is defined).
module tb_ren_conv_wb_dispatch;

    localparam int N  = 11;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             wb_rst_i;
    logic             wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]       wbs_sel_i;
    logic [31:0]      wbs_dat_i, wbs_adr_i;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [N-1:0]     m_wb_rst_o, m_wbs_stb_o, m_wbs_ack_i;
    logic [32*N-1:0]  m_wbs_dat_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ren_conv_wb_dispatch #(
        .NO_OF_INSTS (N),
        .ADDR_BASE   (32'h3000_0000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .m_wb_rst_o  (m_wb_rst_o),
        .m_wbs_stb_o (m_wbs_stb_o),
        .m_wbs_ack_i (m_wbs_ack_i),
        .m_wbs_dat_i (m_wbs_dat_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One bus transfer. dly<0: strobed slave never acks; otherwise it acks on
    // its (dly+1)-th strobe cycle with sdat. Latency counts rising edges after
    // the request cycle until wbs_ack_o is seen.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int dly, input logic [31:0] sdat,
                        input int exp_lat, input logic chk_rd,
                        input logic [31:0] exp_rd, input logic [N-1:0] exp_stb);
        int s = 0;
        int lat = 0;
        logic [31:0] rd = 32'd0;
        logic [N-1:0] seen = '0;
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            m_wbs_ack_i = '0;
            if (wbs_ack_o) begin
                lat = n;
                rd  = wbs_dat_o;
                break;
            end
            if (m_wbs_stb_o != '0) begin
                s++;
                seen |= m_wbs_stb_o;
                if (dly >= 0 && s == dly + 1) begin
                    m_wbs_ack_i = m_wbs_stb_o;
                    for (int i = 0; i < N; i++)
                        if (m_wbs_stb_o[i]) m_wbs_dat_i[32*i +: 32] = sdat;
                end
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (chk_rd) check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_stb"}, 32'(seen), 32'(exp_stb));
        @(posedge clk); #1;
        check({tag, "_onepulse"}, {31'd0, wbs_ack_o}, 32'd0);
        $display("xfer %s we=%0d adr=%08h lat=%0d rd=%08h stb=%03h", tag, we, adr, lat, rd, seen);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'd0; wbs_adr_i = 32'd0;
        m_wbs_ack_i = '0; m_wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mrst", 32'(m_wb_rst_o), 32'h0000_07FF);
        check("rst_ack",  {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat",  wbs_dat_o, 32'd0);
        check("rst_stb",  32'(m_wbs_stb_o), 32'd0);
        @(negedge clk); wb_rst_i = 1'b0;
        @(posedge clk); #1;
        check("post_rst_mrst", 32'(m_wb_rst_o), 32'd0);

        // Slave reads/writes, including the highest slave index.
        xfer("s3_rd",  1'b0, 32'h3000_0304, 32'd0, 4'hF, 2, 32'h1234_5678, 4, 1'b1, 32'h1234_5678, 11'h008);
        xfer("s1_wr",  1'b1, 32'h3000_0100, 32'h0000_AA55, 4'hF, 0, 32'd0, 2, 1'b0, 32'd0, 11'h002);
        xfer("s10_rd", 1'b0, 32'h3000_0A10, 32'd0, 4'hF, 1, 32'hCAFE_000A, 3, 1'b1, 32'hCAFE_000A, 11'h400);

        // CSR block.
        xfer("id_rd",  1'b0, 32'h3000_0F08, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h52C0_000B, 11'h000);
        xfer("csr_oth",1'b0, 32'h3000_0F0C, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_0000, 11'h000);

        // Soft reset and accesses to held slaves.
        xfer("sr_wr5", 1'b1, 32'h3000_0F00, 32'h0000_0005, 4'hF, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        check("sr_mrst5", 32'(m_wb_rst_o), 32'h0000_0005);
        xfer("sr_rd5", 1'b0, 32'h3000_0F00, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_0005, 11'h000);
        xfer("s2_held",1'b0, 32'h3000_0200, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'hBADA_DD02, 11'h000);
        xfer("s2_hwr", 1'b1, 32'h3000_0200, 32'h1111_2222, 4'hF, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        xfer("s0_held",1'b0, 32'h3000_0000, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'hBADA_DD00, 11'h000);
        xfer("sr_b0",  1'b1, 32'h3000_0F00, 32'hFFFF_FFFF, 4'h1, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        xfer("sr_rdb0",1'b0, 32'h3000_0F00, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_00FF, 11'h000);
        xfer("sr_b1",  1'b1, 32'h3000_0F00, 32'hFFFF_FFFF, 4'h2, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        xfer("sr_rdb1",1'b0, 32'h3000_0F00, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_07FF, 11'h000);
        check("sr_mrst_all", 32'(m_wb_rst_o), 32'h0000_07FF);
        xfer("sr_b23", 1'b1, 32'h3000_0F00, 32'h0000_0000, 4'hC, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        xfer("sr_rdb23",1'b0,32'h3000_0F00, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_07FF, 11'h000);
        xfer("sr_clr", 1'b1, 32'h3000_0F00, 32'h0000_0000, 4'hF, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        check("sr_mrst_clr", 32'(m_wb_rst_o), 32'd0);

        // Unmapped index and base mismatch.
        xfer("unm_c",  1'b0, 32'h3000_0C00, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'hBADA_DD0C, 11'h000);
        xfer("unm_bas",1'b0, 32'h3100_0000, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'hBADA_DD00, 11'h000);

        // Master drops cyc while the slave is strobed.
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0200; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("abort_stb_on", 32'(m_wbs_stb_o), 32'h0000_0004);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        check("abort_stb_off", 32'(m_wbs_stb_o), 32'd0);
        check("abort_ack0", {31'd0, wbs_ack_o}, 32'd0);
        @(posedge clk); #1;
        check("abort_ack1", {31'd0, wbs_ack_o}, 32'd0);
        $display("xfer abort adr=30000200");
        xfer("after_ab",1'b0, 32'h3000_0200, 32'd0, 4'hF, 0, 32'h0202_0202, 2, 1'b1, 32'h0202_0202, 11'h004);

`ifdef REN_DISP_TIMEOUT_EN
        xfer("to_rd",  1'b0, 32'h3000_0100, 32'd0, 4'hF, -1, 32'd0, 9, 1'b1, 32'hDEAD_0001, 11'h002);
        xfer("tost_rd",1'b0, 32'h3000_0F04, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h8000_0001, 11'h000);
        xfer("tost_cl",1'b1, 32'h3000_0F04, 32'h8000_0000, 4'hF, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        xfer("tost_r2",1'b0, 32'h3000_0F04, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_0000, 11'h000);
        xfer("to_race",1'b0, 32'h3000_0400, 32'd0, 4'hF, 7, 32'h4444_0004, 9, 1'b1, 32'h4444_0004, 11'h010);
        xfer("tost_r3",1'b0, 32'h3000_0F04, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_0000, 11'h000);
`else
        xfer("tost_rd",1'b0, 32'h3000_0F04, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h0000_0000, 11'h000);
`endif

        // Reset in the middle of a transfer to slave 5, with soft reset armed.
        xfer("sr_arm", 1'b1, 32'h3000_0F00, 32'h0000_0001, 4'hF, -1, 32'd0, 1, 1'b0, 32'd0, 11'h000);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0500; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("mid_stb5", 32'(m_wbs_stb_o), 32'h0000_0020);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wb_rst_i = 1'b1;
        #1;
        check("mid_mrst_all", 32'(m_wb_rst_o), 32'h0000_07FF);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        #1;
        check("mid_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("mid_dat", wbs_dat_o, 32'd0);
        check("mid_stb", 32'(m_wbs_stb_o), 32'd0);
        check("mid_mrst", 32'(m_wb_rst_o), 32'd0);
        m_wbs_ack_i[5] = 1'b1;
        @(posedge clk); #1;
        check("late_ack0", {31'd0, wbs_ack_o}, 32'd0);
        m_wbs_ack_i = '0;
        @(posedge clk); #1;
        check("late_ack1", {31'd0, wbs_ack_o}, 32'd0);
        $display("xfer reset_mid adr=30000500");
        xfer("post_id",1'b0, 32'h3000_0F08, 32'd0, 4'hF, -1, 32'd0, 1, 1'b1, 32'h52C0_000B, 11'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ren_conv_wb_dispatch.md
REN_CONV_WB_DISPATCH -- requirements
Module: ren_conv_wb_dispatch

Interface
REQ-001 SHALL have parameter NO_OF_INSTS, default 11: number of convolver slaves; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BASE, default 32'h3000_0000: user-space base; only adr[31:12] is compared.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: slave ack watchdog limit in cycles; legal range 1..65535.
REQ-004 SHALL have ports as follows (all widths in bits):
- wb_clk_i  in  1  sole clock; every flop on its rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i  in  1  master strobe.
- wbs_cyc_i  in  1  master cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address.
- wbs_ack_o  out  1  ack to master; registered.
- wbs_dat_o  out  32  read data to master; registered.
- m_wb_rst_o  out  NO_OF_INSTS  per-slave reset.
- m_wbs_stb_o  out  NO_OF_INSTS  per-slave strobe; one-hot or zero; registered.
- m_wbs_ack_i  in  NO_OF_INSTS  per-slave ack.
- m_wbs_dat_i  in  32*NO_OF_INSTS  per-slave read data; slave i on bits [32i+31:32i].

Function
REQ-005 SHALL decode a request (stb&cyc in IDLE, adr[31:12]==ADDR_BASE[31:12]) by idx=adr[11:8]: idx<NO_OF_INSTS is slave idx; idx==4'hF is local CSR; any other idx, or a base mismatch, is unmapped.
REQ-006 SHALL implement FSM IDLE, BUSY, ACK; reset state IDLE.
REQ-007 IDLE, slave hit, slave not soft-reset: SHALL latch idx, set m_wbs_stb_o[idx]=1 next cycle, go BUSY.
REQ-008 BUSY: SHALL hold m_wbs_stb_o[idx] until m_wbs_ack_i[idx] is sampled high. It SHALL then clear the strobe, register m_wbs_dat_i slice idx into wbs_dat_o and go ACK.
REQ-009 ACK: SHALL drive wbs_ack_o=1 for exactly one cycle, then go IDLE. ACK state SHALL ignore all slave acks.
REQ-010 Latency: request seen in cycle T, slave acks in cycle T+1+k (k>=0), so wbs_ack_o is high in cycle T+2+k.
REQ-011 Local CSR and unmapped accesses: SHALL go IDLE->ACK, giving wbs_ack_o in cycle T+1. No slave strobe is raised.
REQ-012 Unmapped access, or access to a slave held in soft reset: SHALL return read data 32'hBADA_DD00|idx. Writes to these SHALL be dropped.
REQ-013 CSR 0xF00 SOFT_RST (RW): bit i holds slave i in reset. Writes SHALL honor wbs_sel_i byte lanes. Bits >= NO_OF_INSTS SHALL read 0.
REQ-014 CSR 0xF04 TO_STAT: bit31 sticky timeout flag, bits[3:0] idx of the last slave that timed out. Writing 1 to bit31 SHALL clear the flag.
REQ-015 CSR 0xF08 ID (RO): SHALL read 32'h52C0_0000|NO_OF_INSTS. Other CSR offsets SHALL read 0 and ignore writes.
REQ-016 m_wb_rst_o[i] SHALL equal wb_rst_i | SOFT_RST[i]; this is the only combinational output.
REQ-017 If wbs_cyc_i drops in BUSY: SHALL clear the strobe next cycle and return to IDLE without wbs_ack_o.
REQ-018 If a slave ack arrives in the same cycle the watchdog expires: the ack SHALL win.
REQ-019 A SOFT_RST write SHALL NOT affect a transfer already in BUSY.

Reset
REQ-020 When wb_rst_i=1 at a rising edge, the following SHALL reset on that edge, including mid-transfer:
- FSM to IDLE.
- wbs_ack_o=0, wbs_dat_o=0, m_wbs_stb_o=0.
- SOFT_RST=0, TO_STAT=0, watchdog counter=0.
REQ-021 During reset, m_wb_rst_o SHALL be all ones.

Configuration
REQ-022 Macro REN_DISP_TIMEOUT_EN defined: BUSY SHALL count cycles from 1. When the count reaches TIMEOUT_CYC with no ack, it SHALL:
- clear the strobe;
- load wbs_dat_o=32'hDEAD_0000|idx;
- set TO_STAT;
- go ACK.
REQ-023 Macro REN_DISP_TIMEOUT_EN undefined: BUSY SHALL wait indefinitely, TO_STAT SHALL read 0, and no counter logic SHALL be present.

Verification
REQ-024 Read adr 0x3000_0304, slave 3 acks 2 cycles after its strobe with data 0x1234_5678 -> only m_wbs_stb_o[3] rises; wbs_ack_o pulses once at T+4; wbs_dat_o=0x1234_5678.
REQ-025 Write 0x0000_0005 to 0x3000_0F00, then read 0x3000_0200 -> m_wb_rst_o=...0101; the read acks at T+1 with 0xBADA_DD02; no strobe is raised.
REQ-026 With REN_DISP_TIMEOUT_EN and TIMEOUT_CYC=8, read slave 1, which never acks -> ack arrives 8 BUSY cycles later with 0xDEAD_0001; TO_STAT reads 0x8000_0001; after writing 0x8000_0000 it reads 0.
REQ-027 Read 0x3000_0C00 (idx 12, NO_OF_INSTS=11) and 0x3100_0000 -> each acks at T+1, returning 0xBADA_DD0C and 0xBADA_DD00 respectively.
REQ-028 Assert wb_rst_i one cycle while in BUSY on slave 5 -> next cycle all outputs are 0 and the FSM is IDLE; a late slave-5 ack causes no wbs_ack_o.
REQ-029 Read 0x3000_0F08 -> ack at T+1 with 0x52C0_000B.
